// File: rtl/risc_pkg.sv
// Shared RISC decode definitions.
// Holds the default register-address and opcode widths, the opcodes of the
// two load-type instructions (LDD, POP), and is_load_op(). The control unit
// uses the same function, so both agree on which opcodes write via memory.
package risc_pkg;

  localparam int unsigned DEF_REG_ADDR_W = 3;
  localparam int unsigned DEF_OPCODE_W   = 5;

  localparam logic [DEF_OPCODE_W-1:0] OP_LDD = 5'b10010;
  localparam logic [DEF_OPCODE_W-1:0] OP_POP = 5'b01111;

  function automatic logic is_load_op(input logic [DEF_OPCODE_W-1:0] op);
    return (op == OP_LDD) || (op == OP_POP);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Single scoreboard entry: a down-counter that stops at zero.
// Ports:
//   clk, rst : clock and synchronous active-high reset (count -> 0)
//   hold     : freeze the count (highest priority after reset)
//   load     : reload with LOAD_VAL
//   count    : current value; 0 means the register has no pending load
module sb_counter #(
  parameter int unsigned W        = 1,
  parameter int unsigned LOAD_VAL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         load,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (hold) begin
      count <= count;
    end else if (load) begin
      count <= W'(LOAD_VAL);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/load_use_scoreboard.sv
// Decode-stage load-use hazard unit.
// Every issued load (LDD/POP) arms a per-register countdown of LOAD_LAT
// cycles. While the countdown of a register read by the decode-stage
// instruction is nonzero, the front end is frozen and a bubble goes into
// ID/EX. A memory-stage stall freezes everything, including the countdowns.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   dec_valid         : decode stage holds a real instruction
//   dec_opcode        : decode-stage opcode
//   dec_rsrc/rdst     : source / destination register addresses
//   dec_rsrc_used     : instruction reads dec_rsrc
//   dec_rdst_used     : instruction reads dec_rdst
//   mem_stall         : memory stage busy, pipeline frozen
//   flush             : decode-stage instruction squashed
//   freeze_pc         : hold PC
//   freeze_ifid       : hold IF/ID
//   bubble_idex       : insert NOP into ID/EX
//   busy_vec          : per-register pending-load flags (from counter flops)
//   stall_cnt         : saturating count of hazard bubbles
module load_use_scoreboard
  import risc_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int unsigned OPCODE_W    = DEF_OPCODE_W,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dec_valid,
  input  logic [OPCODE_W-1:0]          dec_opcode,
  input  logic [REG_ADDR_W-1:0]        dec_rsrc,
  input  logic [REG_ADDR_W-1:0]        dec_rdst,
  input  logic                         dec_rsrc_used,
  input  logic                         dec_rdst_used,
  input  logic                         mem_stall,
  input  logic                         flush,
  output logic                         freeze_pc,
  output logic                         freeze_ifid,
  output logic                         bubble_idex,
  output logic [(2**REG_ADDR_W)-1:0]   busy_vec,
  output logic [STALL_CNT_W-1:0]       stall_cnt
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
  localparam int unsigned CNT_W    = $clog2(LOAD_LAT + 1);

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic             isLoad;
  logic             hazard;
  logic             issue;
  logic             frontFreeze;

  assign isLoad = is_load_op(DEF_OPCODE_W'(dec_opcode));

  // Reset gating keeps the control outputs quiet while rst is high even if
  // mem_stall is asserted.
  always_comb begin
    hazard = 1'b0;
    if (!rst && dec_valid && !flush) begin
      hazard = (dec_rsrc_used && busy_vec[dec_rsrc]) ||
               (dec_rdst_used && busy_vec[dec_rdst]);
    end
    frontFreeze = !rst && (hazard || mem_stall);
    issue       = dec_valid && !flush && !hazard && !mem_stall;
  end

  assign freeze_pc   = frontFreeze;
  assign freeze_ifid = frontFreeze;
  assign bubble_idex = hazard && !mem_stall;

  for (genvar r = 0; r < NUM_REGS; r++) begin : gSb
    sb_counter #(
      .W        (CNT_W),
      .LOAD_VAL (LOAD_LAT)
    ) uCnt (
      .clk   (clk),
      .rst   (rst),
      .hold  (mem_stall),
      .load  (issue && isLoad && (dec_rdst == REG_ADDR_W'(r))),
      .count (cnt[r])
    );
    assign busy_vec[r] = (cnt[r] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (bubble_idex && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_load_use_scoreboard.sv
module tb_load_use_scoreboard;

  localparam logic [4:0] LDD = 5'b10010;
  localparam logic [4:0] POP = 5'b01111;
  localparam logic [4:0] ADD = 5'b00001;

  typedef struct {
    int         id;
    int         sel;      // 0: LOAD_LAT=1, 1: LOAD_LAT=2, 2: LOAD_LAT=3
    bit         chk;
    logic       rst;
    logic       valid;
    logic [4:0] op;
    logic [2:0] rsrc;
    logic [2:0] rdst;
    logic       su;
    logic       du;
    logic       ms;
    logic       fl;
    logic       eFreeze;
    logic       eBubble;
    logic [7:0] eBusy;
    logic [3:0] eStall;
  } vecT;

  logic       clk;
  logic       rst, decValid, srcUsed, dstUsed, memStall, flush;
  logic [4:0] decOp;
  logic [2:0] decRsrc, decRdst;

  logic [2:0] fPc, fIfid, bub;
  logic [7:0] busy [3];
  logic [3:0] sCnt [3];

  int  nVec = 0;
  int  nMis = 0;
  vecT tbl [$];
  vecT sbq [$];
  int  rowId = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  load_use_scoreboard #(.REG_ADDR_W(3), .OPCODE_W(5), .LOAD_LAT(1), .STALL_CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .dec_valid(decValid), .dec_opcode(decOp),
    .dec_rsrc(decRsrc), .dec_rdst(decRdst), .dec_rsrc_used(srcUsed),
    .dec_rdst_used(dstUsed), .mem_stall(memStall), .flush(flush),
    .freeze_pc(fPc[0]), .freeze_ifid(fIfid[0]), .bubble_idex(bub[0]),
    .busy_vec(busy[0]), .stall_cnt(sCnt[0]));

  load_use_scoreboard #(.REG_ADDR_W(3), .OPCODE_W(5), .LOAD_LAT(2), .STALL_CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .dec_valid(decValid), .dec_opcode(decOp),
    .dec_rsrc(decRsrc), .dec_rdst(decRdst), .dec_rsrc_used(srcUsed),
    .dec_rdst_used(dstUsed), .mem_stall(memStall), .flush(flush),
    .freeze_pc(fPc[1]), .freeze_ifid(fIfid[1]), .bubble_idex(bub[1]),
    .busy_vec(busy[1]), .stall_cnt(sCnt[1]));

  load_use_scoreboard #(.REG_ADDR_W(3), .OPCODE_W(5), .LOAD_LAT(3), .STALL_CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .dec_valid(decValid), .dec_opcode(decOp),
    .dec_rsrc(decRsrc), .dec_rdst(decRdst), .dec_rsrc_used(srcUsed),
    .dec_rdst_used(dstUsed), .mem_stall(memStall), .flush(flush),
    .freeze_pc(fPc[2]), .freeze_ifid(fIfid[2]), .bubble_idex(bub[2]),
    .busy_vec(busy[2]), .stall_cnt(sCnt[2]));

  function automatic vecT mk(int sel, bit chk, logic r, logic v, logic [4:0] op,
                             logic [2:0] rs, logic [2:0] rd, logic su, logic du,
                             logic ms, logic fl, logic ef, logic eb,
                             logic [7:0] ebusy, logic [3:0] es);
    vecT x;
    x.id = 0; x.sel = sel; x.chk = chk; x.rst = r; x.valid = v; x.op = op;
    x.rsrc = rs; x.rdst = rd; x.su = su; x.du = du; x.ms = ms; x.fl = fl;
    x.eFreeze = ef; x.eBubble = eb; x.eBusy = ebusy; x.eStall = es;
    return x;
  endfunction

  task automatic apply(input vecT v);
    @(posedge clk);
    #1;
    rst      = v.rst;
    decValid = v.valid;
    decOp    = v.op;
    decRsrc  = v.rsrc;
    decRdst  = v.rdst;
    srcUsed  = v.su;
    dstUsed  = v.du;
    memStall = v.ms;
    flush    = v.fl;
    v.id     = rowId;
    rowId++;
    sbq.push_back(v);
  endtask

  // Outputs are sampled mid-cycle: combinational outputs reflect the inputs
  // driven this cycle, registered outputs reflect the last rising edge.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      vecT e;
      e = sbq.pop_front();
      if (e.chk) begin
        nVec++;
        if (fPc[e.sel] !== e.eFreeze || fIfid[e.sel] !== e.eFreeze ||
            bub[e.sel] !== e.eBubble || busy[e.sel] !== e.eBusy ||
            sCnt[e.sel] !== e.eStall) begin
          nMis++;
          $display("FAIL row%0d lat%0d: got pc=%b ifid=%b bub=%b busy=%h stall=%0d, want pc=%b ifid=%b bub=%b busy=%h stall=%0d",
                   e.id, e.sel + 1, fPc[e.sel], fIfid[e.sel], bub[e.sel],
                   busy[e.sel], sCnt[e.sel], e.eFreeze, e.eFreeze, e.eBubble,
                   e.eBusy, e.eStall);
        end
      end
    end
  end

  initial begin
    #200000;
    nMis++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    int s;
    rst = 1'b1; decValid = 1'b0; decOp = '0; decRsrc = '0; decRdst = '0;
    srcUsed = 1'b0; dstUsed = 1'b0; memStall = 1'b0; flush = 1'b0;

    // ---- LOAD_LAT=1: reset, basic load-use, independent op, flush, mem_stall
    tbl.push_back(mk(0, 0, 1, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 1, 1, LDD, 3, 3, 0, 0, 1, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 0, 1, LDD, 0, 3, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 0, 1, ADD, 3, 1, 1, 1, 0, 0, 1, 1, 8'h08, 0));
    tbl.push_back(mk(0, 1, 0, 1, ADD, 3, 1, 1, 1, 0, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 1, 0, 1, LDD, 0, 2, 0, 0, 0, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 1, 0, 1, ADD, 1, 4, 1, 1, 0, 0, 0, 0, 8'h04, 1));
    tbl.push_back(mk(0, 1, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 1, 0, 1, LDD, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 1, 0, 1, LDD, 0, 1, 0, 0, 0, 0, 0, 0, 8'h02, 1));
    tbl.push_back(mk(0, 1, 0, 1, ADD, 1, 0, 1, 0, 0, 1, 0, 0, 8'h02, 1));
    tbl.push_back(mk(0, 1, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 1, 0, 0, ADD, 0, 0, 0, 0, 1, 0, 1, 0, 8'h00, 1));
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();

    // ---- LOAD_LAT=1: stall counter saturation at 15
    s = 1;
    for (int i = 0; i < 18; i++) begin
      apply(mk(0, 1, 0, 1, LDD, 0, 7, 0, 0, 0, 0, 0, 0, 8'h00, 4'(s)));
      apply(mk(0, 1, 0, 1, ADD, 7, 0, 1, 0, 0, 0, 1, 1, 8'h80, 4'(s)));
      if (s < 15) s++;
    end
    apply(mk(0, 1, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 15));

    // ---- LOAD_LAT=2: mem_stall during the load shadow
    tbl.push_back(mk(1, 0, 1, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 1, 0, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 0, 1, LDD, 0, 6, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 0, 1, ADD, 6, 0, 1, 0, 1, 0, 1, 0, 8'h40, 0));
    tbl.push_back(mk(1, 1, 0, 1, ADD, 6, 0, 1, 0, 0, 0, 1, 1, 8'h40, 0));
    tbl.push_back(mk(1, 1, 0, 1, ADD, 6, 0, 1, 0, 0, 0, 1, 1, 8'h40, 1));
    tbl.push_back(mk(1, 1, 0, 1, ADD, 6, 0, 1, 0, 0, 0, 0, 0, 8'h00, 2));

    // ---- LOAD_LAT=3: POP use, same-register reload, flush, reset mid-stall
    tbl.push_back(mk(2, 0, 1, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(2, 1, 1, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(2, 1, 0, 1, POP, 0, 5, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(2, 1, 0, 1, ADD, 0, 5, 0, 1, 0, 0, 1, 1, 8'h20, 0));
    tbl.push_back(mk(2, 1, 0, 1, ADD, 0, 5, 0, 1, 0, 0, 1, 1, 8'h20, 1));
    tbl.push_back(mk(2, 1, 0, 1, ADD, 0, 5, 0, 1, 0, 0, 1, 1, 8'h20, 2));
    tbl.push_back(mk(2, 1, 0, 1, ADD, 0, 5, 0, 1, 0, 0, 0, 0, 8'h00, 3));
    tbl.push_back(mk(2, 1, 0, 1, LDD, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 3));
    tbl.push_back(mk(2, 1, 0, 1, LDD, 0, 1, 0, 0, 0, 0, 0, 0, 8'h02, 3));
    tbl.push_back(mk(2, 1, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 8'h02, 3));
    tbl.push_back(mk(2, 1, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 8'h02, 3));
    tbl.push_back(mk(2, 1, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 8'h02, 3));
    tbl.push_back(mk(2, 1, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 3));
    tbl.push_back(mk(2, 1, 0, 1, LDD, 0, 3, 0, 0, 0, 0, 0, 0, 8'h00, 3));
    tbl.push_back(mk(2, 1, 0, 1, ADD, 3, 0, 1, 0, 0, 1, 0, 0, 8'h08, 3));
    tbl.push_back(mk(2, 1, 1, 1, ADD, 3, 0, 1, 0, 1, 0, 0, 0, 8'h08, 3));
    tbl.push_back(mk(2, 1, 0, 1, ADD, 3, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0));
    foreach (tbl[i]) apply(tbl[i]);

    @(negedge clk);
    #1;
    nVec++;
    if (sbq.size() != 0) begin
      nMis++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/load_use_scoreboard.md
# load_use_scoreboard

Parametrised load-use hazard unit for the decode stage of the 5-stage RISC pipeline. It tracks every in-flight load (LDD, POP) in a per-register countdown scoreboard. It stalls any decode-stage instruction whose source or destination register is still pending, for as many cycles as the configured load latency requires. It also handles memory-stage back-pressure and flush, and keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- REG_ADDR_W, 3: register address width; NUM_REGS = 2**REG_ADDR_W.
- OPCODE_W, 5: opcode width.
- LOAD_LAT, 1: cycles after a load issues before its result is forwardable; legal range 1..7.
- STALL_CNT_W, 16: width of the stall statistics counter.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- dec_valid, input, 1: the decode stage holds a real instruction.
- dec_opcode, input, OPCODE_W: opcode of the decode-stage instruction.
- dec_rsrc, input, REG_ADDR_W: source register address.
- dec_rdst, input, REG_ADDR_W: destination register address. It is read as a source by ALU-type ops and is the write target of loads.
- dec_rsrc_used, input, 1: the instruction reads dec_rsrc.
- dec_rdst_used, input, 1: the instruction reads dec_rdst.
- mem_stall, input, 1: the memory stage is busy; the whole pipeline is frozen.
- flush, input, 1: the decode-stage instruction is squashed this cycle (branch taken or interrupt).
- freeze_pc, output, 1: hold PC.
- freeze_ifid, output, 1: hold the IF/ID register.
- bubble_idex, output, 1: insert a NOP into ID/EX.
- busy_vec, output, NUM_REGS: registered; bit r is set while cnt[r] != 0.
- stall_cnt, output, STALL_CNT_W: registered; saturating count of hazard-stall cycles.

## Operation
- Scoreboard: one counter cnt[r] per register, width clog2(LOAD_LAT+1).
- is_load = dec_opcode is OP_LDD (5'b10010) or OP_POP (5'b01111).
- hazard = dec_valid & !flush & ((dec_rsrc_used & cnt[dec_rsrc]!=0) | (dec_rdst_used & cnt[dec_rdst]!=0)).
- A load's own write target dec_rdst does not participate in the hazard check unless dec_rdst_used is set. POP sets dec_rdst_used=0.
- issue = dec_valid & !flush & !hazard & !mem_stall.
- Output equations, combinational:
  - freeze_pc = freeze_ifid = hazard | mem_stall.
  - bubble_idex = hazard & !mem_stall.
- Counter update, per cycle, in priority order:
  - rst: all cnt = 0.
  - mem_stall: all cnt hold.
  - issue & is_load: cnt[dec_rdst] = LOAD_LAT. This overrides that register's decrement and any older pending value (same-register reload). All other nonzero counters decrement by 1.
  - Otherwise: every nonzero cnt decrements by 1; a counter at 0 stays at 0.
- flush does not clear the scoreboard; loads already past decode still complete.
- stall_cnt increments when bubble_idex = 1 and saturates at all-ones.

## Timing
- Reset: cnt all 0, busy_vec 0, stall_cnt 0. While rst is high, freeze_pc, freeze_ifid and bubble_idex are forced to 0 regardless of inputs.
- Load issued in cycle t: a dependent instruction in decode during cycles t+1 .. t+LOAD_LAT sees hazard=1.
  - An immediately following dependent instruction stalls exactly LOAD_LAT cycles and issues in cycle t+LOAD_LAT+1.
- mem_stall cycles do not count toward load latency; stall duration extends by one cycle per mem_stall cycle.
- busy_vec reflects the counters after the edge, i.e. one cycle behind the combinational hazard decision.
- Reset asserted mid-stall: pending loads are forgotten. The next cycle has no hazard.

## Structure
- Package risc_pkg holds:
  - opcode constants OP_LDD and OP_POP;
  - REG_ADDR_W and OPCODE_W defaults;
  - an is_load_op() function shared with the control unit.
- One sub-module, sb_counter: a single saturating-at-zero down-counter with load and hold inputs, instantiated NUM_REGS times via generate.
- Hazard compare, output logic and stall_cnt live in the top module.

## Test plan
- Basic load-use, LOAD_LAT=1:
  - LDD R3 issued at t, then ADD reading rsrc=R3 at t+1.
  - Required: freeze_pc=1 and bubble_idex=1 for 1 cycle; ADD issues at t+2; stall_cnt=1.
- Multi-cycle latency, LOAD_LAT=3:
  - POP R5 followed immediately by an instruction using rdst=R5 (dec_rdst_used=1).
  - Required: 3 stall cycles; busy_vec[5]=1 for cycles t+1..t+3.
- Independent instruction:
  - LDD R2, then an op on R1/R4.
  - Required: no hazard; stall_cnt unchanged.
- mem_stall interaction, LOAD_LAT=2:
  - LDD R6 at t; mem_stall high during t+1.
  - Required: cnt[6] holds at 2 during t+1; hazard persists; bubble_idex=0 during t+1; dependent instruction issues at t+4.
- Flush and reload:
  - Dependent instruction flushed during the stall: hazard drops to 0 immediately.
  - Back-to-back LDD R1, LDD R1: cnt[1] reloads to LOAD_LAT.
- Reset mid-stall:
  - Assert rst while cnt[3]=2.
  - Required: all outputs 0 during reset; busy_vec=0 and no hazard on the first cycle after release.
  - Saturation: preload stall_cnt near max (STALL_CNT_W=4); it holds at 15.
